i2c_slave_regif: RTL

//   I2C target (slave) that answers a 7-bit address. It exposes an 8-bit register space
//   to local logic through a simple register port.
//   It is the far end of the bus driven by i2c_master. Write transfers are: address, register

---
 rtl/i2c_slave_regif.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regif.sv
// I2C target answering a 7-bit address and exposing an 8-bit register space.
// Writes carry a register pointer, then data bytes; reads stream bytes from the pointer.
module i2c_slave_regif #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_t,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       rd_done
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        WAIT_STOP
    } state_t;

    logic [SYNC_N-1:0] scl_sync_r;
    logic [SYNC_N-1:0] sda_sync_r;
    logic              scl_d_r;
    logic              sda_d_r;

    logic scl_s;
    logic sda_s;
    logic scl_rise_s;
    logic scl_fall_s;
    logic start_s;
    logic stop_s;

    state_t     state_r;
    state_t     state_s;
    logic [3:0] bit_cnt_r;
    logic [3:0] bit_cnt_s;
    logic [7:0] shift_r;
    logic [7:0] shift_s;
    logic       sda_t_r;
    logic       sda_t_s;
    logic [7:0] reg_addr_r;
    logic [7:0] reg_addr_s;
    logic [7:0] reg_wdata_r;
    logic [7:0] reg_wdata_s;
    logic       reg_we_r;
    logic       reg_we_s;
    logic       busy_r;
    logic       busy_s;
    logic       rd_done_r;
    logic       rd_done_s;
    logic       inc_r;
    logic       inc_s;
    logic       mack_r;
    logic       mack_s;

    // Bus input synchronizers plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_sync_r <= {SYNC_N{1'b1}};
            sda_sync_r <= {SYNC_N{1'b1}};
            scl_d_r    <= 1'b1;
            sda_d_r    <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_N-2:0], scl_i};
            sda_sync_r <= {sda_sync_r[SYNC_N-2:0], sda_i};
            scl_d_r    <= scl_sync_r[SYNC_N-1];
            sda_d_r    <= sda_sync_r[SYNC_N-1];
        end
    end

    assign scl_s      = scl_sync_r[SYNC_N-1];
    assign sda_s      = sda_sync_r[SYNC_N-1];
    assign scl_rise_s = scl_s & ~scl_d_r;
    assign scl_fall_s = ~scl_s & scl_d_r;
    // SCL must be high on both samples so an SCL edge never masquerades as START/STOP.
    assign start_s    = scl_s & scl_d_r & ~sda_s & sda_d_r;
    assign stop_s     = scl_s & scl_d_r & sda_s & ~sda_d_r;

    // FSM state and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 4'd0;
            shift_r     <= 8'h00;
            sda_t_r     <= 1'b1;
            reg_addr_r  <= 8'h00;
            reg_wdata_r <= 8'h00;
            reg_we_r    <= 1'b0;
            busy_r      <= 1'b0;
            rd_done_r   <= 1'b0;
            inc_r       <= 1'b0;
            mack_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            bit_cnt_r   <= bit_cnt_s;
            shift_r     <= shift_s;
            sda_t_r     <= sda_t_s;
            reg_addr_r  <= reg_addr_s;
            reg_wdata_r <= reg_wdata_s;
            reg_we_r    <= reg_we_s;
            busy_r      <= busy_s;
            rd_done_r   <= rd_done_s;
            inc_r       <= inc_s;
            mack_r      <= mack_s;
        end
    end

    // Next-state and next-output logic; bus conditions outrank bit handling.
    always_comb begin
        state_s     = state_r;
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        sda_t_s     = sda_t_r;
        reg_addr_s  = reg_addr_r;
        reg_wdata_s = reg_wdata_r;
        reg_we_s    = 1'b0;
        busy_s      = busy_r;
        rd_done_s   = 1'b0;
        inc_s       = 1'b0;
        mack_s      = mack_r;

        // Pointer bump one clk after a write strobe.
        if (inc_r) begin
            reg_addr_s = reg_addr_r + 8'd1;
        end else begin
            reg_addr_s = reg_addr_r;
        end

        if (stop_s) begin
            state_s   = IDLE;
            sda_t_s   = 1'b1;
            busy_s    = 1'b0;
            bit_cnt_s = 4'd0;
        end else if (start_s) begin
            state_s   = ADDR;
            sda_t_s   = 1'b1;
            bit_cnt_s = 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    sda_t_s = 1'b1;
                end
                ADDR, PTR, WDATA: begin
                    if (scl_rise_s && (bit_cnt_r < 4'd8)) begin
                        shift_s   = {shift_r[6:0], sda_s};
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
                        if (state_r == PTR) begin
                            sda_t_s    = 1'b0;
                            reg_addr_s = shift_r;
                            state_s    = PTR_ACK;
                        end else if (state_r == WDATA) begin
                            sda_t_s = 1'b0;
                            state_s = WDATA_ACK;
                        end else if (shift_r[7:1] == SLAVE_ADDR) begin
                            sda_t_s = 1'b0;
                            busy_s  = 1'b1;
                            state_s = ADDR_ACK;
                        end else begin
                            sda_t_s = 1'b1;
                            state_s = WAIT_STOP;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_s) begin
                        bit_cnt_s = 4'd0;
                        if (shift_r[0]) begin
                            shift_s = reg_rdata;
                            sda_t_s = reg_rdata[7];
                            state_s = RDATA;
                        end else begin
                            sda_t_s = 1'b1;
                            state_s = PTR;
                        end
                    end else begin
                        state_s = ADDR_ACK;
                    end
                end
                PTR_ACK: begin
                    if (scl_fall_s) begin
                        sda_t_s   = 1'b1;
                        bit_cnt_s = 4'd0;
                        state_s   = WDATA;
                    end else begin
                        state_s = PTR_ACK;
                    end
                end
                WDATA_ACK: begin
                    if (scl_rise_s) begin
                        reg_we_s    = 1'b1;
                        reg_wdata_s = shift_r;
                        inc_s       = 1'b1;
                    end else if (scl_fall_s) begin
                        sda_t_s   = 1'b1;
                        bit_cnt_s = 4'd0;
                        state_s   = WDATA;
                    end else begin
                        state_s = WDATA_ACK;
                    end
                end
                RDATA: begin
                    if (scl_rise_s && (bit_cnt_r < 4'd8)) begin
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end else if (scl_fall_s) begin
                        if (bit_cnt_r == 4'd8) begin
                            sda_t_s = 1'b1;
                            mack_s  = 1'b0;
                            state_s = RDATA_ACK;
                        end else begin
                            shift_s = {shift_r[6:0], 1'b0};
                            sda_t_s = shift_r[6];
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r;
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise_s) begin
                        if (!sda_s) begin
                            mack_s     = 1'b1;
                            reg_addr_s = reg_addr_r + 8'd1;
                        end else begin
                            rd_done_s = 1'b1;
                            busy_s    = 1'b0;
                            state_s   = WAIT_STOP;
                        end
                    end else if (scl_fall_s && mack_r) begin
                        shift_s   = reg_rdata;
                        sda_t_s   = reg_rdata[7];
                        bit_cnt_s = 4'd0;
                        mack_s    = 1'b0;
                        state_s   = RDATA;
                    end else begin
                        state_s = RDATA_ACK;
                    end
                end
                WAIT_STOP: begin
                    sda_t_s = 1'b1;
                end
                default: begin
                    sda_t_s = 1'b1;
                    state_s = IDLE;
                end
            endcase
        end
    end

    assign sda_t     = sda_t_r;
    assign reg_addr  = reg_addr_r;
    assign reg_wdata = reg_wdata_r;
    assign reg_we    = reg_we_r;
    assign busy      = busy_r;
    assign rd_done   = rd_done_r;

endmodule
